tdm_demux_8x1: RTL and testbench

Time-division demultiplexer, the receive end of an 8-channel TDM link whose transmit side selects one of eight inputs per slot on a 3-bit select. It accepts one word per valid beat on a serial TDM stream. It aligns to a frame-sync marker and steers each word into one of eight channel registers. It presents all eight channels together, double-buffered, with a one-cycle frame strobe. It sits downstream of the 8:1 TDM mux path and feeds parallel per-channel logic.

---
 rtl/tdm_demux_8x1_pkg.sv | 19 +
 rtl/tdm_demux_8x1_slot_counter.sv | 48 ++++
 rtl/tdm_demux_8x1.sv | 138 +++++++++++++
 tb/tb_tdm_demux_8x1.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_8x1_pkg.sv
// Shared constants, state encoding and channel slicing helper for the
// 8-channel TDM receive demultiplexer.
package tdm_demux_8x1_pkg;

    localparam int NUM_CH = 8;
    localparam int SLOT_W = 3;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // LSB position of channel k inside a flattened channel vector.
    function automatic int ch_lsb(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/tdm_demux_8x1_slot_counter.sv
// Framing state register plus the 3-bit wrapping slot counter with
// load-to-1 (frame start) and clear (wrap / loss of lock).
module tdm_demux_8x1_slot_counter
    import tdm_demux_8x1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              state_next,
    input  logic              load1,
    input  logic              clr,
    input  logic              inc,
    output logic              state,
    output logic [SLOT_W-1:0] slot,
    output logic              locked
);

    logic              state_reg;
    logic [SLOT_W-1:0] slot_reg;
    logic [SLOT_W-1:0] slot_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
        end
    end

    always_comb begin
        slot_next = slot_reg;
        if (clr)
            slot_next = '0;
        else if (load1)
            slot_next = SLOT_W'(1);
        else if (inc)
            slot_next = slot_reg + SLOT_W'(1);
    end

    always_comb begin
        locked = (state_reg == RECV);
    end

    assign state = state_reg;
    assign slot  = slot_reg;

endmodule

// File: rtl/tdm_demux_8x1.sv
// Receive side of an 8-channel TDM link: aligns on frame_sync, collects
// slot words into a shadow bank and publishes whole frames on dout.
module tdm_demux_8x1
    import tdm_demux_8x1_pkg::*;
#(
    parameter int DATA_W       = 1,
    parameter int CNT_W        = 8,
    parameter int REQUIRE_SYNC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     frame_sync,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     frame_valid,
    output logic                     sync_err,
    output logic [SLOT_W-1:0]        slot,
    output logic                     locked,
    output logic [CNT_W-1:0]         frame_cnt
);

    logic              state;
    logic              state_next;
    logic [SLOT_W-1:0] slot_cnt;
    logic              slot_load1;
    logic              slot_clr;
    logic              slot_inc;
    logic              shadow_we;
    logic [SLOT_W-1:0] shadow_idx;
    logic              frame_done;
    logic              err_next;

    logic [(NUM_CH-1)*DATA_W-1:0] shadow_flat;
    logic [NUM_CH*DATA_W-1:0]     dout_reg;
    logic                         frame_valid_reg;
    logic                         sync_err_reg;
    logic [CNT_W-1:0]             frame_cnt_reg;

    tdm_demux_8x1_slot_counter u_slot_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .state_next (state_next),
        .load1      (slot_load1),
        .clr        (slot_clr),
        .inc        (slot_inc),
        .state      (state),
        .slot       (slot_cnt),
        .locked     (locked)
    );

    // Beat decode: any sync beat restarts the frame at slot 0; a sync
    // seen away from slot 0 additionally flags the aborted frame.
    always_comb begin
        state_next = state;
        slot_load1 = 1'b0;
        slot_clr   = 1'b0;
        slot_inc   = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = slot_cnt;
        frame_done = 1'b0;
        err_next   = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        state_next = RECV;
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        slot_load1 = 1'b1;
                    end
                end
                RECV: begin
                    if (frame_sync) begin
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                        slot_load1 = 1'b1;
                        err_next   = (slot_cnt != '0);
                    end else if (slot_cnt == '0) begin
                        if (REQUIRE_SYNC != 0) begin
                            err_next   = 1'b1;
                            state_next = HUNT;
                            slot_clr   = 1'b1;
                        end else begin
                            shadow_we  = 1'b1;
                            shadow_idx = '0;
                            slot_load1 = 1'b1;
                        end
                    end else if (slot_cnt == LAST_SLOT) begin
                        frame_done = 1'b1;
                        slot_clr   = 1'b1;
                    end else begin
                        shadow_we = 1'b1;
                        slot_inc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Only slots 0..6 need storage; slot 7 goes straight from din to dout.
    generate
        for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    word_reg <= '0;
                else if (shadow_we && shadow_idx == SLOT_W'(gi))
                    word_reg <= din;
            end
            assign shadow_flat[ch_lsb(gi, DATA_W) +: DATA_W] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg        <= '0;
            frame_valid_reg <= 1'b0;
            sync_err_reg    <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            frame_valid_reg <= frame_done;
            sync_err_reg    <= err_next;
            if (frame_done) begin
                dout_reg      <= {din, shadow_flat};
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign dout        = dout_reg;
    assign frame_valid = frame_valid_reg;
    assign sync_err    = sync_err_reg;
    assign slot        = slot_cnt;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_tdm_demux_8x1.sv
// Directed bench: a bit-serial strict-sync instance and a byte-wide,
// free-running, 2-bit-counter instance sharing clock and reset.
module tb_tdm_demux_8x1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       din_a;
    logic       valid_a;
    logic       fs_a;
    logic [7:0] dout_a;
    logic       fv_a;
    logic       se_a;
    logic [2:0] slot_a;
    logic       locked_a;
    logic [7:0] cnt_a;

    logic [7:0]  din_b;
    logic        valid_b;
    logic        fs_b;
    logic [63:0] dout_b;
    logic        fv_b;
    logic        se_b;
    logic [2:0]  slot_b;
    logic        locked_b;
    logic [1:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    tdm_demux_8x1 #(.DATA_W(1), .CNT_W(8), .REQUIRE_SYNC(1)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din_a),
        .din_valid   (valid_a),
        .frame_sync  (fs_a),
        .dout        (dout_a),
        .frame_valid (fv_a),
        .sync_err    (se_a),
        .slot        (slot_a),
        .locked      (locked_a),
        .frame_cnt   (cnt_a)
    );

    tdm_demux_8x1 #(.DATA_W(8), .CNT_W(2), .REQUIRE_SYNC(0)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din_b),
        .din_valid   (valid_b),
        .frame_sync  (fs_b),
        .dout        (dout_b),
        .frame_valid (fv_b),
        .sync_err    (se_b),
        .slot        (slot_b),
        .locked      (locked_b),
        .frame_cnt   (cnt_b)
    );

    // Called at a negedge: apply inputs, return at the next negedge.
    task automatic drive_a(input logic v, input logic fs, input logic d);
        din_a   = d;
        valid_a = v;
        fs_a    = fs;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic v, input logic fs, input logic [7:0] d);
        din_b   = d;
        valid_b = v;
        fs_b    = fs;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din_a = 1'b0; valid_a = 1'b0; fs_a = 1'b0;
        din_b = 8'h00; valid_b = 1'b0; fs_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dout_a !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", dout_a); end
        checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", fv_a); end
        checks++; if (se_a !== 1'b0) begin failures++; $display("FAIL reset_se got=%b exp=0", se_a); end
        checks++; if (slot_a !== 3'd0) begin failures++; $display("FAIL reset_slot got=%0d exp=0", slot_a); end
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", locked_a); end
        checks++; if (cnt_a !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
        checks++; if (dout_b !== 64'h0) begin failures++; $display("FAIL reset_dout_b got=%h exp=0", dout_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [7:0] bits;
        bits = 8'b01001101;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, i == 0, bits[i]);
            if (i < 7) begin
                checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL basic_fv_early beat=%0d got=%b exp=0", i, fv_a); end
                checks++; if (slot_a !== 3'(i + 1)) begin failures++; $display("FAIL basic_slot beat=%0d got=%0d exp=%0d", i, slot_a, i + 1); end
            end
        end
        checks++; if (dout_a !== 8'b01001101) begin failures++; $display("FAIL basic_dout got=%b exp=01001101", dout_a); end
        checks++; if (fv_a !== 1'b1) begin failures++; $display("FAIL basic_fv got=%b exp=1", fv_a); end
        checks++; if (cnt_a !== 8'd1) begin failures++; $display("FAIL basic_cnt got=%0d exp=1", cnt_a); end
        checks++; if (slot_a !== 3'd0) begin failures++; $display("FAIL basic_slot_wrap got=%0d exp=0", slot_a); end
        checks++; if (locked_a !== 1'b1) begin failures++; $display("FAIL basic_locked got=%b exp=1", locked_a); end
        checks++; if (se_a !== 1'b0) begin failures++; $display("FAIL basic_se got=%b exp=0", se_a); end
        drive_a(1'b0, 1'b0, 1'b0);
        checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL basic_fv_pulse got=%b exp=0", fv_a); end
        checks++; if (dout_a !== 8'b01001101) begin failures++; $display("FAIL basic_dout_hold got=%b exp=01001101", dout_a); end
    endtask

    task automatic test_gapped();
        logic [7:0] bits;
        int pulses;
        bits = 8'b01001101;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, i == 0, bits[i]);
            if (fv_a === 1'b1) pulses++;
            if (i == 7) begin
                checks++; if (fv_a !== 1'b1) begin failures++; $display("FAIL gap_fv_last got=%b exp=1", fv_a); end
            end
            for (int g = 0; g < 3; g++) begin
                drive_a(1'b0, 1'b1, 1'b1);
                if (fv_a === 1'b1) pulses++;
            end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL gap_pulses got=%0d exp=1", pulses); end
        checks++; if (dout_a !== 8'b01001101) begin failures++; $display("FAIL gap_dout got=%b exp=01001101", dout_a); end
        checks++; if (cnt_a !== 8'd2) begin failures++; $display("FAIL gap_cnt got=%0d exp=2", cnt_a); end
    endtask

    task automatic test_early_sync();
        drive_a(1'b1, 1'b1, 1'b1);
        drive_a(1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1);
        drive_a(1'b1, 1'b0, 1'b1);
        checks++; if (slot_a !== 3'd4) begin failures++; $display("FAIL early_slot_pre got=%0d exp=4", slot_a); end
        drive_a(1'b1, 1'b1, 1'b0);
        checks++; if (se_a !== 1'b1) begin failures++; $display("FAIL early_se got=%b exp=1", se_a); end
        checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL early_fv got=%b exp=0", fv_a); end
        checks++; if (slot_a !== 3'd1) begin failures++; $display("FAIL early_slot got=%0d exp=1", slot_a); end
        checks++; if (locked_a !== 1'b1) begin failures++; $display("FAIL early_locked got=%b exp=1", locked_a); end
        checks++; if (dout_a !== 8'b01001101) begin failures++; $display("FAIL early_dout_hold got=%b exp=01001101", dout_a); end
        drive_a(1'b0, 1'b0, 1'b0);
        checks++; if (se_a !== 1'b0) begin failures++; $display("FAIL early_se_pulse got=%b exp=0", se_a); end
        for (int i = 1; i < 8; i++) drive_a(1'b1, 1'b0, 1'b1);
        checks++; if (dout_a !== 8'b11111110) begin failures++; $display("FAIL early_dout got=%b exp=11111110", dout_a); end
        checks++; if (fv_a !== 1'b1) begin failures++; $display("FAIL early_fv_done got=%b exp=1", fv_a); end
        checks++; if (cnt_a !== 8'd3) begin failures++; $display("FAIL early_cnt got=%0d exp=3", cnt_a); end
        checks++; if (se_a !== 1'b0) begin failures++; $display("FAIL early_se_done got=%b exp=0", se_a); end
    endtask

    task automatic test_missing_sync();
        drive_a(1'b1, 1'b0, 1'b1);
        checks++; if (se_a !== 1'b1) begin failures++; $display("FAIL miss_se got=%b exp=1", se_a); end
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL miss_locked got=%b exp=0", locked_a); end
        checks++; if (slot_a !== 3'd0) begin failures++; $display("FAIL miss_slot got=%0d exp=0", slot_a); end
        checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL miss_fv got=%b exp=0", fv_a); end
        checks++; if (dout_a !== 8'b11111110) begin failures++; $display("FAIL miss_dout got=%b exp=11111110", dout_a); end
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, 1'b1);
            checks++; if (locked_a !== 1'b0 || slot_a !== 3'd0 || se_a !== 1'b0) begin
                failures++; $display("FAIL miss_hunt beat=%0d got=locked%b/slot%0d/se%b exp=locked0/slot0/se0", i, locked_a, slot_a, se_a);
            end
        end
        drive_a(1'b1, 1'b1, 1'b0);
        checks++; if (locked_a !== 1'b1) begin failures++; $display("FAIL miss_relock got=%b exp=1", locked_a); end
        checks++; if (slot_a !== 3'd1) begin failures++; $display("FAIL miss_relock_slot got=%0d exp=1", slot_a); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] pat;
        pat = 8'b10101010;
        for (int i = 1; i <= 5; i++) drive_a(1'b1, 1'b0, 1'b1);
        checks++; if (slot_a !== 3'd6) begin failures++; $display("FAIL rmid_slot_pre got=%0d exp=6", slot_a); end
        din_a = 1'b0; valid_a = 1'b0; fs_a = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout_a !== 8'h00) begin failures++; $display("FAIL rmid_dout got=%b exp=00000000", dout_a); end
        checks++; if (slot_a !== 3'd0) begin failures++; $display("FAIL rmid_slot got=%0d exp=0", slot_a); end
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL rmid_locked got=%b exp=0", locked_a); end
        checks++; if (cnt_a !== 8'd0) begin failures++; $display("FAIL rmid_cnt got=%0d exp=0", cnt_a); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1'b1, 1'b0, 1'b1);
        drive_a(1'b1, 1'b0, 1'b1);
        checks++; if (locked_a !== 1'b0) begin failures++; $display("FAIL rmid_hunt got=%b exp=0", locked_a); end
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, i == 0, pat[i]);
            if (i < 7) begin
                checks++; if (fv_a !== 1'b0) begin failures++; $display("FAIL rmid_fv_early beat=%0d got=%b exp=0", i, fv_a); end
            end
        end
        checks++; if (dout_a !== 8'b10101010) begin failures++; $display("FAIL rmid_dout_new got=%b exp=10101010", dout_a); end
        checks++; if (fv_a !== 1'b1) begin failures++; $display("FAIL rmid_fv got=%b exp=1", fv_a); end
        checks++; if (cnt_a !== 8'd1) begin failures++; $display("FAIL rmid_cnt_new got=%0d exp=1", cnt_a); end
        drive_a(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int exp_cnt [5];
        logic [63:0] exp_dout;
        exp_cnt = '{1, 2, 3, 0, 1};
        for (int f = 0; f < 5; f++) begin
            exp_dout = '0;
            for (int k = 0; k < 8; k++) begin
                exp_dout[8*k +: 8] = 8'(8'hA0 + k + 8 * f);
                drive_b(1'b1, (f == 0) && (k == 0), 8'(8'hA0 + k + 8 * f));
                if (k < 7) begin
                    checks++; if (fv_b !== 1'b0 || se_b !== 1'b0) begin
                        failures++; $display("FAIL b2b_mid f=%0d k=%0d got=fv%b/se%b exp=fv0/se0", f, k, fv_b, se_b);
                    end
                end
            end
            checks++; if (fv_b !== 1'b1) begin failures++; $display("FAIL b2b_fv f=%0d got=%b exp=1", f, fv_b); end
            checks++; if (cnt_b !== 2'(exp_cnt[f])) begin failures++; $display("FAIL b2b_cnt f=%0d got=%0d exp=%0d", f, cnt_b, exp_cnt[f]); end
            checks++; if (dout_b !== exp_dout) begin failures++; $display("FAIL b2b_dout f=%0d got=%h exp=%h", f, dout_b, exp_dout); end
            checks++; if (locked_b !== 1'b1 || slot_b !== 3'd0) begin
                failures++; $display("FAIL b2b_state f=%0d got=locked%b/slot%0d exp=locked1/slot0", f, locked_b, slot_b);
            end
        end
        drive_b(1'b0, 1'b0, 8'h00);
        checks++; if (fv_b !== 1'b0) begin failures++; $display("FAIL b2b_fv_pulse got=%b exp=0", fv_b); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gapped();
        test_early_sync();
        test_missing_sync();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
